des_key_schedule: RTL
=====================

// Module: des_key_schedule
// PURPOSE
//  Sequential DES key schedule generator for the Triple-DES datapath.
//  - Loads a 64-bit DES key and applies PC-1 once.
//  - Then emits the 16 48-bit round keys (PC-2 of the rotated C/D halves), one per handshake.
//  - Directly feeds the round key operand of the 48-bit expansion/key XOR stage.
//  - Encrypt order K1..K16; decrypt order K16..K1. No key RAM is needed.
// PARAMETERS
//  SHIFT_ONE_MASK  16'h8103  bit r-1 set => round r rotates by 1, else by 2 (FIPS 46-3: rounds 1,2,9,16)
// PORTS
//  clk        in   1   system clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  key_in     in   64  DES key; key_in[63] = DES bit 1; parity bits (DES 8,16..64) ignored
//  load       in   1   start schedule: capture key_in and decrypt this cycle
//  decrypt    in   1   0 = encrypt order K1..K16, 1 = decrypt order K16..K1
//  next       in   1   consumer accepted current round_key; advance
//  round_key  out  48  current round key; bit 47 = PC-2 output bit 1
//  key_valid  out  1   round_key valid and stable
//  round_num  out  4   index in emission order, 0..15
//  busy       out  1   schedule in progress (state ACTIVE)
//  done       out  1   one-cycle pulse after the 16th key is accepted
// BEHAVIOUR
//  Clock/reset: single clock clk; reset rst is synchronous, active-high.
//  Reset: state IDLE; C/D = 0, round_key = 48'h0, key_valid = 0, round_num = 0, busy = 0, done = 0.
//    - rst dominates load/next in the same cycle.
//    - rst mid-schedule aborts immediately; no done pulse.
//  State: 2-state FSM IDLE/ACTIVE, 28-bit C and D registers, 4-bit counter, latched dir bit.
//  IDLE:
//    - load=1 captures {C,D} = PC-1(key_in) and goes to ACTIVE.
//    - If decrypt=0, the captured value is pre-rotated left by 1, giving C1/D1.
//    - If decrypt=1, it is captured unrotated, giving C16 = C0.
//    - dir <= decrypt; counter <= 0.
//  Output in ACTIVE:
//    - round_key = PC-2({C,D}), combinational from registers; key_valid = busy = 1.
//    - round_num = counter.
//    - Latency: load at cycle T -> first key valid at T+1.
//  Handshake:
//    - Advance only when next=1 and key_valid=1.
//    - Otherwise round_key and round_num hold, with no limit on stall length.
//    - next while idle is ignored.
//  Advance with counter<15, let k = counter:
//    - Encrypt: rotate C and D left by shift(k+2).
//    - Decrypt: rotate C and D right by shift(16-k).
//    - counter <= k+1.
//    - shift(r) = 1 if SHIFT_ONE_MASK[r-1], else 2.
//  Advance with counter=15:
//    - Next cycle: state IDLE, key_valid = 0, busy = 0, done = 1 for exactly one cycle, counter = 0.
//    - C/D are not cleared, but round_key is don't-care while key_valid=0.
//  Restart: load=1 while ACTIVE restarts the schedule from the new key_in/decrypt.
//    - load wins over next in the same cycle.
//    - No done pulse for the aborted schedule.
//  Consistency: total rotation over 16 rounds is 28, so encrypt ends with C16=C0, D16=D0.
//  Rotations are 28-bit circular within each half; C and D never mix.
// TESTING
//  T1 encrypt:
//    - key_in=64'h133457799BBCDFF1, decrypt=0, load 1 cycle, next held 1.
//    - Expect K1=48'h1B02EFFC7072, K2=48'h79AED9DBC9E5, K16=48'hCB3D8B0E17F5.
//    - Expect round_num 0..15 on consecutive cycles, then done=1 one cycle.
//  T2 decrypt:
//    - Same key, decrypt=1.
//    - Expect first key 48'hCB3D8B0E17F5 and last (round_num=15) 48'h1B02EFFC7072.
//    - Sequence must be the exact reverse of T1.
//  T3 stall:
//    - T1 with next=0 for 5 cycles at round_num=3.
//    - Expect round_key/round_num/key_valid constant through the stall, then the sequence resumes unchanged.
//  T4 restart:
//    - At round_num=7, assert load and next together with key_in=64'h0123456789ABCDEF.
//    - Expect round_num=0 next cycle with the K1 of the new key, and no done pulse.
//  T5 reset:
//    - rst=1 at round_num=9 concurrent with next.
//    - Expect all outputs at reset values next cycle.
//    - next alone while idle -> key_valid stays 0.
//  T6 parity:
//    - Two keys differing only in parity bits (key_in ^ 64'h0101010101010101).
//    - Expect identical 16-key sequences.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Purpose : Handshake and data bundle between the DES key schedule and its
//           driver (key loader / round datapath).
// Signals : key_in[63:0]     64-bit DES key, key_in[63] is DES bit 1
//           load             capture key_in/decrypt and (re)start the schedule
//           decrypt          0 = K1..K16, 1 = K16..K1
//           next             consumer accepted the current round key
//           round_key[47:0]  current round key, bit 47 is PC-2 output bit 1
//           key_valid        round_key valid and stable
//           round_num[3:0]   position in emission order, 0..15
//           busy             schedule in progress
//           done             one-cycle pulse after the 16th key is accepted
// Modports: master drives key/load/decrypt/next; slave (the schedule) drives
//           the round key and status.
interface des_key_schedule_if;
  logic [63:0] key_in;
  logic        load;
  logic        decrypt;
  logic        next;
  logic [47:0] round_key;
  logic        key_valid;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;

  modport master (
    output key_in, load, decrypt, next,
    input  round_key, key_valid, round_num, busy, done
  );

  modport slave (
    input  key_in, load, decrypt, next,
    output round_key, key_valid, round_num, busy, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// Purpose : Sequential DES key schedule. PC-1 is applied once at load, then
//           the C/D halves are rotated one round per accepted key and PC-2 of
//           the current halves is presented as the round key. Encrypt order
//           walks C1/D1..C16/D16 by left rotations; decrypt order starts at
//           C16/D16 (= C0/D0) and walks back by right rotations, so no key
//           storage is needed.
// Ports   : clk  system clock, rising edge
//           rst  synchronous active-high reset
//           bus  des_key_schedule_if.slave (key_in, load, decrypt, next in;
//                round_key, key_valid, round_num, busy, done out)
// Params  : SHIFT_ONE_MASK  bit r-1 set => round r rotates by 1, else by 2
module des_key_schedule #(
  parameter logic [15:0] SHIFT_ONE_MASK = 16'h8103
) (
  input  logic               clk,
  input  logic               rst,
  des_key_schedule_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // PC-1: output bit i+1 takes DES key bit PC1[i] (bit 1 = key_in[63]).
  localparam logic [6:0] PC1 [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // PC-2: output bit i+1 takes C/D bit PC2[i] (bit 1 = C[27]).
  localparam logic [6:0] PC2 [48] = '{
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,
    7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,
    7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55,
    7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53,
    7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
  };

  // 28-bit circular rotations by 1 (two=0) or 2 (two=1).
  function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_r, state_nxt;
  logic [27:0] c_r, c_nxt;
  logic [27:0] d_r, d_nxt;
  logic [3:0]  cnt_r, cnt_nxt;
  logic        dir_r, dir_nxt;
  logic        done_r, done_nxt;

  logic [55:0] pc1_s;
  logic [55:0] cd_s;
  logic [47:0] round_key_s;
  logic        shift_two_s;
  logic        unused_parity_s;

  // The DES parity bits never reach PC-1; fold them into a sink.
  assign unused_parity_s = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                             bus.key_in[24], bus.key_in[16], bus.key_in[8],  bus.key_in[0]};

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_s[55 - g] = bus.key_in[7'd64 - PC1[g]];
  end

  assign cd_s = {c_r, d_r};

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign round_key_s[47 - g] = cd_s[7'd56 - PC2[g]];
  end

  // Rotation amount for the step leaving round position cnt_r:
  // encrypt goes to round cnt_r+2, decrypt undoes round 16-cnt_r.
  always_comb begin
    shift_two_s = 1'b0;
    if (dir_r) begin
      shift_two_s = ~SHIFT_ONE_MASK[4'd15 - cnt_r];
    end else begin
      shift_two_s = ~SHIFT_ONE_MASK[cnt_r + 4'd1];
    end
  end

  // Next-state, C/D, counter and done-pulse logic; load beats next.
  always_comb begin
    state_nxt = state_r;
    c_nxt     = c_r;
    d_nxt     = d_r;
    cnt_nxt   = cnt_r;
    dir_nxt   = dir_r;
    done_nxt  = 1'b0;
    if (bus.load) begin
      state_nxt = ACTIVE;
      cnt_nxt   = 4'd0;
      dir_nxt   = bus.decrypt;
      if (bus.decrypt) begin
        c_nxt = pc1_s[55:28];
        d_nxt = pc1_s[27:0];
      end else begin
        c_nxt = rot_left(pc1_s[55:28], 1'b0);
        d_nxt = rot_left(pc1_s[27:0], 1'b0);
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt = IDLE;
        end
        ACTIVE: begin
          if (bus.next) begin
            if (cnt_r == 4'd15) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_r + 4'd1;
              if (dir_r) begin
                c_nxt = rot_right(c_r, shift_two_s);
                d_nxt = rot_right(d_r, shift_two_s);
              end else begin
                c_nxt = rot_left(c_r, shift_two_s);
                d_nxt = rot_left(d_r, shift_two_s);
              end
            end
          end else begin
            state_nxt = ACTIVE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      c_r     <= 28'h0;
      d_r     <= 28'h0;
      cnt_r   <= 4'd0;
      dir_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      c_r     <= c_nxt;
      d_r     <= d_nxt;
      cnt_r   <= cnt_nxt;
      dir_r   <= dir_nxt;
      done_r  <= done_nxt;
    end
  end

  assign bus.round_key = round_key_s;
  assign bus.key_valid = (state_r == ACTIVE);
  assign bus.busy      = (state_r == ACTIVE);
  assign bus.round_num = cnt_r;
  assign bus.done      = done_r;

endmodule
